// File: rtl/tdm_four_mux.sv
// ============================================================================
// Module   : tdm_four_mux
// Brief    : 4-to-1 round-robin TDM multiplexer with a registered, lane-tagged
//            output stage (one-entry holding register).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tdm_four_mux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    input  logic             out_ready
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         last_q, last_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [1:0]         out_sel_q, out_sel_d;

    logic               w_load;
    logic               w_found;
    logic [1:0]         w_winner;
    logic [1:0]         w_cand;
    logic               w_xfer;
    logic [WIDTH-1:0]   w_win_data;

    assign w_load = (state_q == EMPTY) || out_ready;

    // Rotating priority search starting just after the last granted lane.
    always_comb begin
        w_found  = 1'b0;
        w_winner = 2'b00;
        w_cand   = 2'b00;
        for (int k = 0; k < 4; k++) begin
            w_cand = last_q + 2'(k + 1);
            if (!w_found && in_valid[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    assign w_xfer = w_load && w_found;

    always_comb begin
        case (w_winner)
            2'd0:    w_win_data = in_data0;
            2'd1:    w_win_data = in_data1;
            2'd2:    w_win_data = in_data2;
            default: w_win_data = in_data3;
        endcase
    end

    // Gated by rst_n so no lane sees a grant while the block is held in reset.
    always_comb begin
        in_ready = 4'b0000;
        if (w_xfer && rst_n) begin
            in_ready[w_winner] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (w_xfer) begin
            out_data_d  = w_win_data;
            out_sel_d   = w_winner;
            out_valid_d = 1'b1;
            last_d      = w_winner;
            state_d     = FULL;
        end else if (state_q == FULL && out_ready) begin
            // Drained with nothing to refill; data/sel keep stale values.
            out_valid_d = 1'b0;
            state_d     = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            last_q      <= 2'b11;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_tdm_four_mux.sv
// Directed bench for tdm_four_mux: reset, single lane, round-robin,
// backpressure, wrap/skip and asynchronous reset mid-operation.
`default_nettype none

module tb_tdm_four_mux;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [3:0]       in_valid;
    logic [WIDTH-1:0] in_data0;
    logic [WIDTH-1:0] in_data1;
    logic [WIDTH-1:0] in_data2;
    logic [WIDTH-1:0] in_data3;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
    logic             out_ready;

    int vectors;
    int miscompares;

    tdm_four_mux #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] s,
                           input logic [WIDTH-1:0] d);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".sel"},   32'(out_sel),   32'(s));
        chk({tag, ".data"},  32'(out_data),  32'(d));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        out_ready   = 1'b0;
        in_valid    = 4'b1111;
        in_data0    = 8'h10;
        in_data1    = 8'h11;
        in_data2    = 8'h12;
        in_data3    = 8'h13;

        // Reset state, with lanes requesting: no grant may leak out.
        #1;
        chk_out("reset", 1'b0, 2'b00, 8'h00);
        chk("reset.in_ready", 32'(in_ready), 32'h0);
        in_valid = 4'b0000;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;

        // Idle for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle.valid", 32'(out_valid), 32'h0);
            chk("idle.sel", 32'(out_sel), 32'h0);
            chk("idle.in_ready", 32'(in_ready), 32'h0);
        end

        // Single lane 2.
        in_valid  = 4'b0100;
        in_data2  = 8'hA5;
        out_ready = 1'b1;
        #1;
        chk("single.in_ready", 32'(in_ready), 32'b0100);
        tick();
        chk_out("single", 1'b1, 2'b10, 8'hA5);
        in_valid = 4'b0000;
        #1;
        chk("single.drain_ready", 32'(in_ready), 32'h0);
        tick();
        chk("single.drained", 32'(out_valid), 32'h0);

        // Move pointer to lane 3 so the round-robin run starts at lane 0.
        in_data2 = 8'h12;
        in_valid = 4'b1000;
        #1;
        chk("prep.in_ready", 32'(in_ready), 32'b1000);
        tick();
        chk_out("prep", 1'b1, 2'b11, 8'h13);

        // Round-robin, all lanes valid, back-to-back.
        in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr.in_ready", 32'(in_ready), 32'(4'b0001 << (k % 4)));
            tick();
            chk_out("rr", 1'b1, 2'(k % 4), 8'(8'h10 + (k % 4)));
        end

        // Backpressure: lane 1 word held while downstream stalls.
        in_data1 = 8'h3C;
        in_valid = 4'b0010;
        #1;
        chk("bp.load_ready", 32'(in_ready), 32'b0010);
        tick();
        chk_out("bp.load", 1'b1, 2'b01, 8'h3C);
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp.stall_ready", 32'(in_ready), 32'h0);
            tick();
            chk_out("bp.stall", 1'b1, 2'b01, 8'h3C);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_ready", 32'(in_ready), 32'b0100);
        tick();
        chk_out("bp.release", 1'b1, 2'b10, 8'h12);

        // Wrap and skip: bring last to 3, then lanes 1 and 3 alternate.
        in_valid = 4'b1000;
        tick();
        chk_out("wrap.prep", 1'b1, 2'b11, 8'h13);
        in_valid = 4'b1010;
        #1;
        chk("wrap.r1", 32'(in_ready), 32'b0010);
        tick();
        chk_out("wrap.g1", 1'b1, 2'b01, 8'h3C);
        chk("wrap.r3", 32'(in_ready), 32'b1000);
        tick();
        chk_out("wrap.g3", 1'b1, 2'b11, 8'h13);
        chk("wrap.r1b", 32'(in_ready), 32'b0010);
        tick();
        chk_out("wrap.g1b", 1'b1, 2'b01, 8'h3C);

        // Asynchronous reset while a word is held under backpressure.
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        #1;
        chk("mid.pre_valid", 32'(out_valid), 32'h1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("mid.reset", 1'b0, 2'b00, 8'h00);
        chk("mid.reset_ready", 32'(in_ready), 32'h0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid.after_ready", 32'(in_ready), 32'b0001);
        tick();
        chk_out("mid.after", 1'b1, 2'b00, 8'h10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
